regfile_sb: RTL and testbench

Parametrised multi-read register file with integrated write-back scoreboard for the pipelined datapath. It replaces the fixed 32x32 two-read register file. It adds configurable width and depth and same-cycle write-to-read bypass, so writes move to the rising edge. It also tracks per-register pending-write (busy) bits, which the issue stage uses to detect RAW hazards.

---
 rtl/regfile_sb.sv | 86 ++++++++
 tb/tb_regfile_sb.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - parametrised multi-read register file with write-back scoreboard
// Two combinational read ports with same-cycle write bypass, plus per-register busy bits for RAW detection.
module regfile_sb #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2,
  input  logic          iss_valid,
  input  logic [AW-1:0] iss_addr,
  input  logic          flush,
  output logic          busy1,
  output logic          busy2,
  output logic [AW:0]   pend_cnt
);

  localparam int NREG = 1 << AW;
  localparam bit ZR   = (ZERO_REG != 0);

  logic [DW-1:0]   mem [NREG];
  logic [NREG-1:0] bsy;
  logic [NREG-1:0] bsy_nxt;

  logic wr_drop;
  logic iss_drop;
  logic r1_zero;
  logic r2_zero;
  logic r1_hit;
  logic r2_hit;

  assign wr_drop  = ZR && (waddr == '0);
  assign iss_drop = ZR && (iss_addr == '0);
  assign r1_zero  = ZR && (raddr1 == '0);
  assign r2_zero  = ZR && (raddr2 == '0);
  assign r1_hit   = we && (waddr == raddr1);
  assign r2_hit   = we && (waddr == raddr2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we && !wr_drop) begin
      mem[waddr] <= wdata;
    end
  end

  // Issue is applied after write-back clear so a newer owner of the same register keeps it busy.
  always_comb begin
    bsy_nxt = bsy;
    if (flush) begin
      bsy_nxt = '0;
    end else begin
      if (we) bsy_nxt[waddr] = 1'b0;
      if (iss_valid && !iss_drop) bsy_nxt[iss_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bsy <= '0;
    else     bsy <= bsy_nxt;
  end

  // Reset gates the bypass path so nothing driven on the write port leaks out while rst is high.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (!rst && !r1_zero) rdata1 = r1_hit ? wdata : mem[raddr1];
    if (!rst && !r2_zero) rdata2 = r2_hit ? wdata : mem[raddr2];
  end

  assign busy1 = !rst && !r1_zero && bsy[raddr1] && !r1_hit;
  assign busy2 = !rst && !r2_zero && bsy[raddr2] && !r2_hit;

  always_comb begin
    pend_cnt = '0;
    for (int i = 0; i < NREG; i++) pend_cnt = pend_cnt + {{AW{1'b0}}, bsy[i]};
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - self-checking bench for regfile_sb
// Directed vectors on a 32x32 instance, model-checked mixed sequence on a 16x8 instance.
module tb_regfile_sb;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic        flush;
  logic        busy1;
  logic        busy2;
  logic [5:0]  pend_cnt;

  logic        s_we;
  logic [2:0]  s_waddr;
  logic [15:0] s_wdata;
  logic [2:0]  s_raddr1;
  logic [2:0]  s_raddr2;
  logic [15:0] s_rdata1;
  logic [15:0] s_rdata2;
  logic        s_iss_valid;
  logic [2:0]  s_iss_addr;
  logic        s_flush;
  logic        s_busy1;
  logic        s_busy2;
  logic [3:0]  s_pend_cnt;

  int n_cmp;
  int n_err;

  logic [15:0] m_mem [8];
  logic [7:0]  m_bsy;

  regfile_sb u_dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .flush(flush),
    .busy1(busy1), .busy2(busy2), .pend_cnt(pend_cnt)
  );

  regfile_sb #(.DW(16), .AW(3), .ZERO_REG(1)) u_small (
    .clk(clk), .rst(rst), .we(s_we), .waddr(s_waddr), .wdata(s_wdata),
    .raddr1(s_raddr1), .raddr2(s_raddr2), .rdata1(s_rdata1), .rdata2(s_rdata2),
    .iss_valid(s_iss_valid), .iss_addr(s_iss_addr), .flush(s_flush),
    .busy1(s_busy1), .busy2(s_busy2), .pend_cnt(s_pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_rd(input logic [2:0] a);
    if (a == 3'd0) return 16'h0;
    if (s_we && s_waddr == a) return s_wdata;
    return m_mem[a];
  endfunction

  function automatic logic m_busy(input logic [2:0] a);
    return (a != 3'd0) && m_bsy[a] && !(s_we && s_waddr == a);
  endfunction

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
    iss_valid = 1'b0; iss_addr = '0; flush = 1'b0;
    s_we = 1'b0; s_waddr = '0; s_wdata = '0; s_raddr1 = '0; s_raddr2 = '0;
    s_iss_valid = 1'b0; s_iss_addr = '0; s_flush = 1'b0;
    for (int i = 0; i < 8; i++) m_mem[i] = '0;
    m_bsy = '0;

    // reset state on every address
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i);
      raddr2 = 5'(31 - i);
      #1;
      check("rst_rdata1", 64'(rdata1), 64'h0);
      check("rst_rdata2", 64'(rdata2), 64'h0);
      check("rst_busy1", 64'(busy1), 64'h0);
      check("rst_busy2", 64'(busy2), 64'h0);
    end
    check("rst_pend", 64'(pend_cnt), 64'h0);
    we = 1'b1; waddr = 5'd5; wdata = 32'hCAFEF00D; raddr1 = 5'd5;
    iss_valid = 1'b1; iss_addr = 5'd6; raddr2 = 5'd6;
    #1;
    check("rst_bypass_gated", 64'(rdata1), 64'h0);
    @(posedge clk); #1;
    check("rst_edge_busy2", 64'(busy2), 64'h0);
    check("rst_edge_pend", 64'(pend_cnt), 64'h0);

    @(negedge clk);
    rst = 1'b0; we = 1'b0; iss_valid = 1'b0;
    #1;
    check("post_rst_rdata1", 64'(rdata1), 64'h0);
    check("post_rst_pend", 64'(pend_cnt), 64'h0);

    @(negedge clk);
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; raddr1 = 5'd5;
    #1 check("bypass_r5", 64'(rdata1), 64'hDEADBEEF);
    @(negedge clk);
    we = 1'b0;
    #1 check("array_r5", 64'(rdata1), 64'hDEADBEEF);

    @(negedge clk);
    we = 1'b1; waddr = 5'd0; wdata = 32'h1234; raddr1 = 5'd0; raddr2 = 5'd0;
    #1;
    check("r0_bypass", 64'(rdata1), 64'h0);
    check("r0_bypass2", 64'(rdata2), 64'h0);
    @(negedge clk);
    we = 1'b0;
    #1;
    check("r0_array", 64'(rdata1), 64'h0);
    check("r0_pend", 64'(pend_cnt), 64'h0);

    @(negedge clk);
    iss_valid = 1'b1; iss_addr = 5'd7; raddr2 = 5'd7;
    #1 check("iss_r7_same_cycle", 64'(busy2), 64'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      iss_valid = 1'b0;
      #1;
      check("idle_busy2", 64'(busy2), 64'h1);
      check("idle_pend", 64'(pend_cnt), 64'h1);
    end
    @(negedge clk);
    we = 1'b1; waddr = 5'd7; wdata = 32'h55;
    #1;
    check("wb_busy2", 64'(busy2), 64'h0);
    check("wb_rdata2", 64'(rdata2), 64'h55);
    check("wb_pend", 64'(pend_cnt), 64'h1);
    @(negedge clk);
    we = 1'b0;
    #1;
    check("after_wb_pend", 64'(pend_cnt), 64'h0);
    check("after_wb_rdata2", 64'(rdata2), 64'h55);

    @(negedge clk);
    we = 1'b1; waddr = 5'd9; wdata = 32'h99; iss_valid = 1'b1; iss_addr = 5'd9; raddr1 = 5'd9;
    #1 check("wb_iss_r9_busy1", 64'(busy1), 64'h0);
    @(negedge clk);
    we = 1'b0; iss_valid = 1'b0;
    #1;
    check("set_wins_busy1", 64'(busy1), 64'h1);
    check("set_wins_pend", 64'(pend_cnt), 64'h1);
    check("set_wins_rdata1", 64'(rdata1), 64'h99);

    @(negedge clk);
    we = 1'b1; waddr = 5'd9; wdata = 32'h99; iss_valid = 1'b1; iss_addr = 5'd1;
    @(negedge clk);
    we = 1'b0; iss_addr = 5'd2;
    @(negedge clk);
    iss_addr = 5'd3;
    @(negedge clk);
    flush = 1'b1; iss_valid = 1'b1; iss_addr = 5'd4; raddr1 = 5'd4; raddr2 = 5'd3;
    #1;
    check("pre_flush_pend", 64'(pend_cnt), 64'h3);
    check("pre_flush_busy2", 64'(busy2), 64'h1);
    @(negedge clk);
    flush = 1'b0; iss_valid = 1'b0;
    #1;
    check("flush_pend", 64'(pend_cnt), 64'h0);
    check("flush_busy1", 64'(busy1), 64'h0);
    check("flush_busy2", 64'(busy2), 64'h0);
    raddr1 = 5'd5; raddr2 = 5'd7;
    #1;
    check("flush_keep_r5", 64'(rdata1), 64'hDEADBEEF);
    check("flush_keep_r7", 64'(rdata2), 64'h55);

    // asynchronous reset in the middle of operation
    @(negedge clk);
    iss_valid = 1'b1; iss_addr = 5'd10;
    @(negedge clk);
    iss_valid = 1'b0; raddr2 = 5'd10;
    #1;
    check("pre_arst_pend", 64'(pend_cnt), 64'h1);
    check("pre_arst_busy2", 64'(busy2), 64'h1);
    we = 1'b1; waddr = 5'd5; wdata = 32'hAAAA5555;
    #1 rst = 1'b1;
    #1;
    check("arst_rdata1", 64'(rdata1), 64'h0);
    check("arst_pend", 64'(pend_cnt), 64'h0);
    check("arst_busy2", 64'(busy2), 64'h0);
    @(negedge clk);
    rst = 1'b0; we = 1'b0;
    raddr2 = 5'd7;
    #1;
    check("arst_mem_r5", 64'(rdata1), 64'h0);
    check("arst_mem_r7", 64'(rdata2), 64'h0);
    check("arst_pend_after", 64'(pend_cnt), 64'h0);

    // mixed issue / write-back / flush on the 16x8 instance
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      s_we        = 1'($urandom_range(0, 1));
      s_waddr     = 3'($urandom_range(0, 7));
      s_wdata     = 16'($urandom);
      s_raddr1    = 3'($urandom_range(0, 7));
      s_raddr2    = (c % 4 == 0) ? s_waddr : 3'($urandom_range(0, 7));
      s_iss_valid = 1'($urandom_range(0, 1));
      s_iss_addr  = (c % 5 == 0) ? s_waddr : 3'($urandom_range(0, 7));
      s_flush     = ($urandom_range(0, 9) == 0);
      #1;
      check("mix_rdata1", 64'(s_rdata1), 64'(m_rd(s_raddr1)));
      check("mix_rdata2", 64'(s_rdata2), 64'(m_rd(s_raddr2)));
      check("mix_busy1", 64'(s_busy1), 64'(m_busy(s_raddr1)));
      check("mix_busy2", 64'(s_busy2), 64'(m_busy(s_raddr2)));
      check("mix_pend", 64'(s_pend_cnt), 64'($countones(m_bsy)));
      @(posedge clk);
      if (s_we && s_waddr != 3'd0) m_mem[s_waddr] = s_wdata;
      if (s_flush) begin
        m_bsy = '0;
      end else begin
        if (s_we) m_bsy[s_waddr] = 1'b0;
        if (s_iss_valid && s_iss_addr != 3'd0) m_bsy[s_iss_addr] = 1'b1;
      end
    end
    @(negedge clk);
    s_we = 1'b0; s_iss_valid = 1'b0; s_flush = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
